// File: rtl/core_pkg.sv
// Shared definitions for the RV32I core pipeline control: FSM states, the NOP
// encoding and the packed hazard-control bundle with its per-action values.
package core_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        LU_STALL = 1'b1
    } state_t;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef struct packed {
        logic pc_we;
        logic ifid_we;
        logic ifid_flush;
        logic idex_bubble;
        logic pipe_freeze;
    } ctrl_t;

    localparam ctrl_t CTRL_RESET    = '{pc_we: 1'b0, ifid_we: 1'b0, ifid_flush: 1'b1, idex_bubble: 1'b1, pipe_freeze: 1'b0};
    localparam ctrl_t CTRL_FREEZE   = '{pc_we: 1'b0, ifid_we: 1'b0, ifid_flush: 1'b0, idex_bubble: 1'b0, pipe_freeze: 1'b1};
    localparam ctrl_t CTRL_REDIRECT = '{pc_we: 1'b1, ifid_we: 1'b1, ifid_flush: 1'b1, idex_bubble: 1'b1, pipe_freeze: 1'b0};
    localparam ctrl_t CTRL_STALL    = '{pc_we: 1'b0, ifid_we: 1'b0, ifid_flush: 1'b0, idex_bubble: 1'b1, pipe_freeze: 1'b0};
    localparam ctrl_t CTRL_FETCH    = '{pc_we: 1'b0, ifid_we: 1'b1, ifid_flush: 1'b1, idex_bubble: 1'b0, pipe_freeze: 1'b0};
    localparam ctrl_t CTRL_RUN      = '{pc_we: 1'b1, ifid_we: 1'b1, ifid_flush: 1'b0, idex_bubble: 1'b0, pipe_freeze: 1'b0};

endpackage

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: drives PC / IF/ID / ID/EX enables and flushes for
// load-use stalls, branch redirects, fetch waits and data-memory freezes.
//
// state    | meaning
// RUN      | normal flow; a load-use hit stalls here for the first bubble
// LU_STALL | extra load-use bubbles pending, bcnt = bubbles still to insert
module hazard_ctrl
    import core_pkg::*;
#(
    parameter int LOAD_BUBBLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_raddr,
    input  logic [4:0]       rs2_raddr,
    input  logic             use_rs1,
    input  logic             use_rs2,
    input  logic             idex_mem_read,
    input  logic [4:0]       idex_rd,
    input  logic             branch_taken_EX,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             pipe_freeze,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [2:0] BUBBLE_INIT = 3'(LOAD_BUBBLES - 1);

    state_t     state, state_nxt;
    logic [2:0] bcnt, bcnt_nxt;
    ctrl_t      ctrl;
    logic       lu_hit;
    logic       flush_ev;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        lu_hit = idex_mem_read && (idex_rd != 5'd0) &&
                 ((use_rs1 && (rs1_raddr == idex_rd)) ||
                  (use_rs2 && (rs2_raddr == idex_rd)));
    end

    always_comb begin
        ctrl      = CTRL_RUN;
        state_nxt = state;
        bcnt_nxt  = bcnt;
        flush_ev  = 1'b0;
        if (rst) begin
            ctrl = CTRL_RESET;
        end else if (!dmem_ready) begin
            ctrl = CTRL_FREEZE;
        end else if (branch_taken_EX) begin
            // the ID instruction is flushed, so any pending load-use stall is moot
            ctrl      = CTRL_REDIRECT;
            state_nxt = RUN;
            bcnt_nxt  = 3'd0;
            flush_ev  = 1'b1;
        end else if (state == LU_STALL) begin
            ctrl     = CTRL_STALL;
            bcnt_nxt = bcnt - 3'd1;
            if (bcnt == 3'd1) begin
                state_nxt = RUN;
            end
        end else if (lu_hit) begin
            ctrl = CTRL_STALL;
            if (LOAD_BUBBLES > 1) begin
                state_nxt = LU_STALL;
                bcnt_nxt  = BUBBLE_INIT;
            end
        end else if (!imem_ready) begin
            ctrl = CTRL_FETCH;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            bcnt      <= 3'd0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= state_nxt;
            bcnt  <= bcnt_nxt;
            if (!ctrl.pc_we) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
            if (flush_ev) begin
                flush_cnt <= sat_inc(flush_cnt);
            end
        end
    end

    assign pc_we       = ctrl.pc_we;
    assign ifid_we     = ctrl.ifid_we;
    assign ifid_flush  = ctrl.ifid_flush;
    assign idex_bubble = ctrl.idex_bubble;
    assign pipe_freeze = ctrl.pipe_freeze;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (2 bubbles / 16-bit counters and
// 1 bubble / 4-bit counters) share stimulus; vectors, sequences, random model.
module tb_hazard_ctrl;

    localparam logic [4:0] E_RUN    = 5'b11000;
    localparam logic [4:0] E_FREEZE = 5'b00001;
    localparam logic [4:0] E_REDIR  = 5'b11110;
    localparam logic [4:0] E_STALL  = 5'b00010;
    localparam logic [4:0] E_FETCH  = 5'b01100;
    localparam logic [4:0] E_RESET  = 5'b00110;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1_raddr, rs2_raddr, idex_rd;
    logic       use_rs1, use_rs2, idex_mem_read, branch_taken_EX, imem_ready, dmem_ready;

    logic        pc_we_a, ifid_we_a, ifid_flush_a, idex_bubble_a, pipe_freeze_a;
    logic [15:0] stall_cnt_a, flush_cnt_a;
    logic        pc_we_b, ifid_we_b, ifid_flush_b, idex_bubble_b, pipe_freeze_b;
    logic [3:0]  stall_cnt_b, flush_cnt_b;
    logic [4:0]  ctrl_a, ctrl_b;

    int total = 0;
    int bad   = 0;

    assign ctrl_a = {pc_we_a, ifid_we_a, ifid_flush_a, idex_bubble_a, pipe_freeze_a};
    assign ctrl_b = {pc_we_b, ifid_we_b, ifid_flush_b, idex_bubble_b, pipe_freeze_b};

    always #5 clk = ~clk;

    hazard_ctrl #(.LOAD_BUBBLES(2), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .rs1_raddr(rs1_raddr), .rs2_raddr(rs2_raddr),
        .use_rs1(use_rs1), .use_rs2(use_rs2), .idex_mem_read(idex_mem_read),
        .idex_rd(idex_rd), .branch_taken_EX(branch_taken_EX),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .pc_we(pc_we_a), .ifid_we(ifid_we_a), .ifid_flush(ifid_flush_a),
        .idex_bubble(idex_bubble_a), .pipe_freeze(pipe_freeze_a),
        .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a)
    );

    hazard_ctrl #(.LOAD_BUBBLES(1), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .rs1_raddr(rs1_raddr), .rs2_raddr(rs2_raddr),
        .use_rs1(use_rs1), .use_rs2(use_rs2), .idex_mem_read(idex_mem_read),
        .idex_rd(idex_rd), .branch_taken_EX(branch_taken_EX),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .pc_we(pc_we_b), .ifid_we(ifid_we_b), .ifid_flush(ifid_flush_b),
        .idex_bubble(idex_bubble_b), .pipe_freeze(pipe_freeze_b),
        .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b)
    );

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       mr;
        logic [4:0] rd;
        logic       br;
        logic       im;
        logic       dm;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        rs1_raddr = 5'd0; rs2_raddr = 5'd0; use_rs1 = 1'b0; use_rs2 = 1'b0;
        idex_mem_read = 1'b0; idex_rd = 5'd0; branch_taken_EX = 1'b0;
        imem_ready = 1'b1; dmem_ready = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_idle();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Reference: pend = load-use stall cycles still owed by the instruction in ID.
    function automatic void model(input int lb, input int pend, output logic [4:0] c, output int npend);
        logic lu;
        lu = idex_mem_read && idex_rd != 0 &&
             ((use_rs1 && rs1_raddr == idex_rd) || (use_rs2 && rs2_raddr == idex_rd));
        npend = pend;
        if (!dmem_ready)          c = E_FREEZE;
        else if (branch_taken_EX) begin c = E_REDIR; npend = 0; end
        else if (pend > 0 || lu)  begin c = E_STALL; npend = ((pend > 0) ? pend : lb) - 1; end
        else if (!imem_ready)     c = E_FETCH;
        else                      c = E_RUN;
    endfunction

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    initial begin
        vecs[0]  = '{5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b1, E_STALL};
        vecs[1]  = '{5'd0, 5'd7, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 1'b1, 1'b1, E_STALL};
        vecs[2]  = '{5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, E_RUN};
        vecs[3]  = '{5'd1, 5'd5, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b1, E_RUN};
        vecs[4]  = '{5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 5'd5, 1'b0, 1'b1, 1'b1, E_RUN};
        vecs[5]  = '{5'd4, 5'd6, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b1, 1'b1, E_RUN};
        vecs[6]  = '{5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, E_REDIR};
        vecs[7]  = '{5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, E_FREEZE};
        vecs[8]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, E_FETCH};
        vecs[9]  = '{5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1, E_STALL};
        vecs[10] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, E_REDIR};
        vecs[11] = '{5'd9, 5'd9, 1'b1, 1'b1, 1'b0, 5'd9, 1'b0, 1'b1, 1'b1, E_RUN};

        // reset values, sampled while rst is held
        rst = 1'b1;
        set_idle();
        #12;
        chk("reset_ctrl_a", 32'(ctrl_a), 32'(E_RESET));
        chk("reset_ctrl_b", 32'(ctrl_b), 32'(E_RESET));
        chk("reset_stall_a", 32'(stall_cnt_a), 0);
        chk("reset_flush_a", 32'(flush_cnt_a), 0);
        @(negedge clk);
        rst = 1'b0;

        // first-cycle decision table, from a clean RUN state each time
        for (int i = 0; i < 12; i++) begin
            do_reset();
            rs1_raddr = vecs[i].rs1; rs2_raddr = vecs[i].rs2;
            use_rs1 = vecs[i].u1; use_rs2 = vecs[i].u2;
            idex_mem_read = vecs[i].mr; idex_rd = vecs[i].rd;
            branch_taken_EX = vecs[i].br; imem_ready = vecs[i].im; dmem_ready = vecs[i].dm;
            #1;
            chk($sformatf("vec%0d_a", i), 32'(ctrl_a), 32'(vecs[i].exp));
            chk($sformatf("vec%0d_b", i), 32'(ctrl_b), 32'(vecs[i].exp));
        end

        // load-use: lw x5 in EX, add x6,x5,x7 in ID
        do_reset();
        idex_mem_read = 1'b1; idex_rd = 5'd5; rs1_raddr = 5'd5; use_rs1 = 1'b1; rs2_raddr = 5'd7; use_rs2 = 1'b1;
        #1;
        chk("lu_c1_a", 32'(ctrl_a), 32'(E_STALL));
        step();
        set_idle();
        #1;
        chk("lu_c2_a", 32'(ctrl_a), 32'(E_STALL));
        chk("lu_c2_b", 32'(ctrl_b), 32'(E_RUN));
        step();
        chk("lu_c3_a", 32'(ctrl_a), 32'(E_RUN));
        chk("lu_stall_a", 32'(stall_cnt_a), 2);
        chk("lu_stall_b", 32'(stall_cnt_b), 1);

        // branch with lu_hit in the same cycle
        do_reset();
        idex_mem_read = 1'b1; idex_rd = 5'd5; rs1_raddr = 5'd5; use_rs1 = 1'b1; branch_taken_EX = 1'b1;
        #1;
        chk("br_lu_a", 32'(ctrl_a), 32'(E_REDIR));
        step();
        set_idle();
        #1;
        chk("br_lu_next_a", 32'(ctrl_a), 32'(E_RUN));
        step();
        chk("br_lu_stall_a", 32'(stall_cnt_a), 0);
        chk("br_lu_flush_a", 32'(flush_cnt_a), 1);

        // branch held through a 3-cycle data-memory freeze
        do_reset();
        branch_taken_EX = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("frz%0d_a", i), 32'(ctrl_a), 32'(E_FREEZE));
            step();
        end
        dmem_ready = 1'b1;
        #1;
        chk("frz_redir_a", 32'(ctrl_a), 32'(E_REDIR));
        step();
        set_idle();
        #1;
        chk("frz_stall_a", 32'(stall_cnt_a), 3);
        chk("frz_flush_a", 32'(flush_cnt_a), 1);
        chk("frz_flush_b", 32'(flush_cnt_b), 1);

        // two-cycle instruction fetch wait
        do_reset();
        imem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk($sformatf("fw%0d_a", i), 32'(ctrl_a), 32'(E_FETCH));
            step();
        end
        imem_ready = 1'b1;
        #1;
        chk("fw_done_a", 32'(ctrl_a), 32'(E_RUN));
        chk("fw_stall_a", 32'(stall_cnt_a), 2);

        // reset asserted while dut_a is in its last pending bubble
        do_reset();
        idex_mem_read = 1'b1; idex_rd = 5'd5; rs1_raddr = 5'd5; use_rs1 = 1'b1;
        step();
        set_idle();
        #1;
        chk("rst_mid_pre_a", 32'(ctrl_a), 32'(E_STALL));
        rst = 1'b1;
        #1;
        chk("rst_mid_ctrl_a", 32'(ctrl_a), 32'(E_RESET));
        chk("rst_mid_stall_a", 32'(stall_cnt_a), 0);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("rst_mid_after_a", 32'(ctrl_a), 32'(E_RUN));
        chk("rst_mid_cnt_a", 32'(stall_cnt_a), 0);

        // saturation of the 4-bit stall counter
        do_reset();
        imem_ready = 1'b0;
        for (int i = 0; i < 20; i++) step();
        set_idle();
        #1;
        chk("sat_stall_b", 32'(stall_cnt_b), 15);
        chk("sat_stall_a", 32'(stall_cnt_a), 20);

        // randomized traffic against the reference
        begin
            int pa, pb, npa, npb, sa, sb, fa, fb;
            logic [4:0] ea, eb;
            do_reset();
            pa = 0; pb = 0; sa = 0; sb = 0; fa = 0; fb = 0;
            for (int c = 0; c < 3000; c++) begin
                rs1_raddr = 5'($urandom_range(0, 3));
                rs2_raddr = 5'($urandom_range(0, 3));
                idex_rd = 5'($urandom_range(0, 3));
                use_rs1 = 1'($urandom_range(0, 1));
                use_rs2 = 1'($urandom_range(0, 1));
                idex_mem_read = ($urandom_range(0, 99) < 50);
                branch_taken_EX = ($urandom_range(0, 99) < 12);
                imem_ready = ($urandom_range(0, 99) < 80);
                dmem_ready = ($urandom_range(0, 99) < 85);
                #1;
                model(2, pa, ea, npa);
                model(1, pb, eb, npb);
                chk("rnd_ctrl_a", 32'(ctrl_a), 32'(ea));
                chk("rnd_ctrl_b", 32'(ctrl_b), 32'(eb));
                chk("rnd_stall_a", 32'(stall_cnt_a), 32'(sat(sa, 16)));
                chk("rnd_stall_b", 32'(stall_cnt_b), 32'(sat(sb, 4)));
                chk("rnd_flush_b", 32'(flush_cnt_b), 32'(sat(fb, 4)));
                chk("rnd_flush_a", 32'(flush_cnt_a), 32'(sat(fa, 16)));
                step();
                pa = npa; pb = npb;
                if (!ea[4]) sa++;
                if (!eb[4]) sb++;
                if (ea == E_REDIR) fa++;
                if (eb == E_REDIR) fb++;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage RV32I core. Sits beside the IF/ID and ID/EX pipeline registers and drives their enables and flushes. Sequences load-use stalls (parameterised bubble count), taken-branch redirects, instruction-memory wait bubbles and data-memory freezes. Keeps saturating stall and flush performance counters.

## Interface
- LOAD_BUBBLES, default 1, bubbles inserted per load-use hazard (1..7; 1 = full forwarding, 2 = no MEM→EX forward)
- CNT_W, default 16, width of each performance counter
- clk  input  1  core clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- rs1_raddr  input  5  rs1 field of instruction in ID
- rs2_raddr  input  5  rs2 field of instruction in ID
- use_rs1 / use_rs2  input  1 each  ID instruction actually reads rs1 / rs2
- idex_mem_read  input  1  instruction in EX is a load
- idex_rd  input  5  destination register of instruction in EX
- branch_taken_EX  input  1  branch/jump in EX redirects PC this cycle
- imem_ready  input  1  instruction fetch completes this cycle
- dmem_ready  input  1  data access in MEM completes (tie 1 when no access)
- pc_we  output  1  PC register load enable
- ifid_we  output  1  IF/ID register load enable
- ifid_flush  output  1  IF/ID loads NOP (0x00000013) instead of instr_IF
- idex_bubble  output  1  ID/EX loads a bubble (all control bits 0)
- pipe_freeze  output  1  hold ID/EX, EX/MEM and MEM/WB
- stall_cnt  output  CNT_W  cycles with pc_we=0 since reset, saturating
- flush_cnt  output  CNT_W  taken-branch flushes since reset, saturating

## Operation
- Control outputs are Mealy: combinational from state and current inputs. Counters and state are registered.
- Hazard `lu_hit` = idex_mem_read & idex_rd≠0 & ((use_rs1 & rs1_raddr==idex_rd) | (use_rs2 & rs2_raddr==idex_rd)).
- Action priority, highest first:
  1. FREEZE (dmem_ready=0): pc_we=0, ifid_we=0, ifid_flush=0, idex_bubble=0, pipe_freeze=1; state and bubble counter hold.
  2. REDIRECT (branch_taken_EX): pc_we=1, ifid_we=1, ifid_flush=1, idex_bubble=1; flush_cnt+1; state → RUN.
  3. LU_STALL (lu_hit in RUN, or state LU_STALL): pc_we=0, ifid_we=0, idex_bubble=1.
  4. FETCH_WAIT (imem_ready=0): pc_we=0, ifid_we=1, ifid_flush=1.
  5. RUN: pc_we=1, ifid_we=1, all flush/bubble/freeze outputs 0.
- States: RUN, LU_STALL; 3-bit bubble counter bcnt.
  - RUN + lu_hit, not pre-empted: if LOAD_BUBBLES>1, go to LU_STALL with bcnt=LOAD_BUBBLES-1; otherwise stay in RUN.
  - LU_STALL, not pre-empted: stall; bcnt-1; when bcnt==1, go to RUN.
  - A REDIRECT in LU_STALL aborts the stall: go to RUN, clear bcnt.
- stall_cnt increments on every cycle with pc_we=0, including FREEZE; saturates at all-ones.
- flush_cnt saturates at all-ones.

## Timing
- Reset (asynchronous assert, synchronous release on first clk edge after deassert):
  - state=RUN, bcnt=0, both counters 0.
  - While rst=1: pc_we=0, ifid_we=0, ifid_flush=1, idex_bubble=1, pipe_freeze=0.
- Control latency is zero cycles; a hazard visible in cycle n is acted on at the edge ending cycle n.
- Load-use costs exactly LOAD_BUBBLES stall cycles, plus any interleaved FREEZE cycles.
- Simultaneous events:
  - branch_taken_EX with lu_hit: REDIRECT only; the ID instruction is flushed, so no stall.
  - dmem_ready=0 with branch_taken_EX: FREEZE; the branch is still in EX next cycle and redirects when dmem_ready=1.
- Reset mid-stall returns to RUN immediately; the pending bubbles are discarded.

## Structure
- Shared package `core_pkg`: state enum {RUN, LU_STALL}, NOP_INSTR constant 32'h00000013, bubble control encoding.
- Single module; no sub-module. The saturating counter may be a local function.

## Test plan
- Load-use: `lw x5` in EX (idex_rd=5, idex_mem_read=1), ID `add x6,x5,x7` (rs1=5, use_rs1=1), LOAD_BUBBLES=2 → pc_we=0, idex_bubble=1 for exactly 2 cycles, then RUN; stall_cnt=2.
- Zero register: idex_rd=0 with rs1=0 → no stall; use_rs2=0 with rs2 match → no stall.
- Branch with lu_hit in the same cycle → ifid_flush=1, idex_bubble=1, pc_we=1, no stall follows; flush_cnt=1.
- Branch during freeze: dmem_ready=0 for 3 cycles with branch_taken_EX held → pipe_freeze=1 for 3 cycles, then one REDIRECT cycle; stall_cnt=3, flush_cnt=1.
- imem_ready=0 for 2 cycles → pc_we=0 and ifid_flush=1 for 2 cycles, ifid_we=1 throughout.
- Assert rst in LU_STALL with bcnt=1 → outputs take reset values immediately; after release, RUN with counters 0. Separately, CNT_W=4 with 20 stall cycles → stall_cnt holds 15.
